critical_error_reporter: RTL and testbench
==========================================

// Module: critical_error_reporter
// PURPOSE
//  Core-side producer of the difftest CriticalErrorEvent. Collects per-hart critical error sources
//  (ROB hang, L2 uncorrectable ECC, bus error, ...) and emits the event record the difftest sink
//  consumes: valid, criticalError, coreid. Adds source pipelining, one-shot reporting, a sticky lock,
//  saturating error count and an optional heartbeat, so the simulator sees each new error exactly once.
// PARAMETERS
//  NUM_SRC           8     number of error source bits
//  SYNC_STAGES       2     register stages on io_errSrc before detection (>=1)
//  CNT_W             8     width of saturating error counter
//  HEARTBEAT_PERIOD  1024  cycles between heartbeat events; 0 disables heartbeat
// PORTS
//  clock               in   1                  core clock
//  reset               in   1                  synchronous, active-high reset
//  io_hartId           in   8                  hart id, copied to io_event_coreid on every event
//  io_errSrc           in   NUM_SRC            level or pulse error sources, bit i = source i
//  io_errMask          in   NUM_SRC            1 = source enabled; applied at pipeline output, unregistered
//  io_clear            in   1                  software/debug clear of the lock
//  io_event_valid      out  1                  event strobe to difftest sink (drives sink enable/io_valid)
//  io_event_critical   out  1                  criticalError field of the event
//  io_event_coreid     out  8                  coreid field of the event
//  io_locked           out  1                  sticky: a critical error has been reported, not yet cleared
//  io_firstSrc         out  $clog2(NUM_SRC)    index of source that triggered the lock
//  io_errCount         out  CNT_W              detection cycles since lock, saturating
// BEHAVIOUR
//  Reset: state=IDLE; pipeline, io_event_*, io_locked, io_firstSrc, io_errCount, heartbeat counter = 0.
//  Pipeline: io_errSrc passes through SYNC_STAGES regs; hit = pipe_out & io_errMask; any = |hit.
//  FSM (all outputs registered):
//   IDLE:   any=1 -> REPORT; capture io_firstSrc = lowest set index of hit; io_errCount = 1.
//   REPORT: io_event_valid=1, io_event_critical=1 for exactly this one cycle; io_locked=1; -> LOCKED.
//           any=1 in REPORT increments io_errCount.
//   LOCKED: io_locked held; each cycle with any=1 increments io_errCount, saturating at 2^CNT_W-1.
//           io_firstSrc frozen. No further error events emitted.
//           io_clear=1 -> IDLE; io_locked, io_firstSrc, io_errCount cleared next cycle.
//   io_clear is ignored in IDLE and REPORT.
//  Latency: source asserted at cycle t (masked-in) -> io_event_valid high in cycle t+SYNC_STAGES+1.
//  Clear collision: clear wins; a pulse source coinciding with the clear cycle is dropped; a level
//   source still present re-triggers from IDLE on the next cycle.
//  Heartbeat (HEARTBEAT_PERIOD>0): counter runs in IDLE and LOCKED; on reaching HEARTBEAT_PERIOD-1
//   emit one-cycle io_event_valid with io_event_critical = io_locked; counter restarts at 0.
//   Counter also restarts on any emitted event. A REPORT event takes priority over a heartbeat due the
//   same cycle; the heartbeat is not deferred.
//  io_event_coreid = io_hartId registered in the same cycle io_event_valid is set; 0 otherwise.
//  io_event_critical = 0 whenever io_event_valid = 0.
//  Reset mid-REPORT or mid-LOCKED: next cycle all outputs 0, FSM IDLE, pipeline flushed.
// TESTING
//  1 reset, hartId=3, mask=0xFF, errSrc[5] pulse 1 cycle at t=10 -> valid=1, critical=1, coreid=3 at
//    t=13 only; locked=1, firstSrc=5, errCount=1.
//  2 errSrc=0x24 simultaneous -> firstSrc=2; mask=0xFB same stimulus -> firstSrc=5.
//  3 after lock, errSrc[0] held 300 cycles with CNT_W=8 -> errCount saturates at 255; no extra event.
//  4 io_clear with errSrc[1] level high -> locked drops for one cycle, re-triggers,
//    second event with firstSrc=1.
//  5 HEARTBEAT_PERIOD=16, no errors -> valid pulse every 16 cycles, critical=0;
//    after lock, heartbeats carry critical=1.
//  6 reset asserted during REPORT -> valid=0, locked=0, errCount=0 next cycle; re-arm works afterwards.

Source files
------------

// File: rtl/critical_error_reporter.sv
// Critical error event producer for the difftest sink.
// Error sources pass through a short register pipeline and are then masked. The first masked-in
// error raises a single critical event and locks the block. While locked, the block counts
// further error cycles with saturation until software clears the lock. An optional heartbeat
// emits periodic events that carry the current lock state in the critical field.
module critical_error_reporter #(
  parameter int unsigned NUM_SRC          = 8,
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned CNT_W            = 8,
  parameter int unsigned HEARTBEAT_PERIOD = 1024
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [7:0]                 io_hartId,
  input  logic [NUM_SRC-1:0]         io_errSrc,
  input  logic [NUM_SRC-1:0]         io_errMask,
  input  logic                       io_clear,
  output logic                       io_event_valid,
  output logic                       io_event_critical,
  output logic [7:0]                 io_event_coreid,
  output logic                       io_locked,
  output logic [$clog2(NUM_SRC)-1:0] io_firstSrc,
  output logic [CNT_W-1:0]           io_errCount
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned HB_W  = (HEARTBEAT_PERIOD > 1) ? $clog2(HEARTBEAT_PERIOD) : 1;
  localparam bit          HB_EN = (HEARTBEAT_PERIOD > 0);

  // Only meaningful when the heartbeat is enabled.
  localparam logic [HB_W-1:0]  HbLast = HB_W'(HEARTBEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReport = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  // --------------------------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------------------------
  logic [NUM_SRC-1:0] pipe_q [SYNC_STAGES];

  logic [1:0]       state_q, state_d;
  logic             locked_q, locked_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [HB_W-1:0]  hb_q, hb_d;

  logic             valid_q, valid_d;
  logic             crit_q, crit_d;
  logic [7:0]       coreid_q, coreid_d;

  // --------------------------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------------------------
  logic [NUM_SRC-1:0] hit;
  logic               any;
  logic [IDX_W-1:0]   first_idx;
  logic [CNT_W-1:0]   cnt_inc;
  logic               report_fire;
  logic               hb_run;
  logic               hb_due;
  logic               hb_fire;
  logic               ev_fire;

  // Source pipeline: flushed on reset so a stale pulse can not re-trigger after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= io_errSrc;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Mask applies to the pipeline output, so mask changes take effect immediately.
  always_comb begin
    hit = pipe_q[SYNC_STAGES-1] & io_errMask;
    any = |hit;
  end

  // Lowest set index of the masked hit vector wins.
  always_comb begin
    first_idx = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

  // Saturating increment of the error counter.
  always_comb begin
    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  end

  // Report/lock FSM next state, together with lock, first source and error count.
  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    report_fire = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d     = StReport;
          locked_d    = 1'b1;
          first_d     = first_idx;
          cnt_d       = {{(CNT_W-1){1'b0}}, 1'b1};
          report_fire = 1'b1;
        end
      end
      StReport: begin
        // Clear is ignored here; the report cycle always completes into the lock.
        state_d = StLocked;
        if (any) begin
          cnt_d = cnt_inc;
        end
      end
      StLocked: begin
        // Clear wins over a coincident error; that cycle's error is dropped.
        if (io_clear) begin
          state_d  = StIdle;
          locked_d = 1'b0;
          first_d  = '0;
          cnt_d    = '0;
        end else if (any) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d  = StIdle;
        locked_d = 1'b0;
        first_d  = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // Heartbeat counter: runs outside the report cycle and restarts on every emitted event.
  always_comb begin
    hb_run  = HB_EN && (state_q != StReport);
    hb_due  = hb_run && (hb_q == HbLast);
    // A report due in the same cycle swallows the heartbeat; it is not deferred.
    hb_fire = hb_due && !report_fire;
    if (!HB_EN || report_fire || hb_due) begin
      hb_d = '0;
    end else if (hb_run) begin
      hb_d = hb_q + 1'b1;
    end else begin
      hb_d = hb_q;
    end
  end

  // Event record for the sink: critical on a report, current lock state on a heartbeat.
  always_comb begin
    ev_fire  = report_fire | hb_fire;
    valid_d  = ev_fire;
    crit_d   = report_fire | (hb_fire & locked_q);
    coreid_d = ev_fire ? io_hartId : 8'h00;
  end

  // Registered FSM, status and event outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      locked_q <= 1'b0;
      first_q  <= '0;
      cnt_q    <= '0;
      hb_q     <= '0;
      valid_q  <= 1'b0;
      crit_q   <= 1'b0;
      coreid_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
      hb_q     <= hb_d;
      valid_q  <= valid_d;
      crit_q   <= crit_d;
      coreid_q <= coreid_d;
    end
  end

  assign io_event_valid    = valid_q;
  assign io_event_critical = crit_q;
  assign io_event_coreid   = coreid_q;
  assign io_locked         = locked_q;
  assign io_firstSrc       = first_q;
  assign io_errCount       = cnt_q;

endmodule

// File: tb/tb_critical_error_reporter.sv
// Bench for critical_error_reporter: two instances share stimulus, one without heartbeat and one
// with a 16-cycle heartbeat. A behavioural model predicts both every cycle; directed literal
// checks pin the model on the main scenarios.
module tb_critical_error_reporter;

  localparam int NSRC = 8;
  localparam int SYNC = 2;
  localparam int CMAX = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hart;
  logic [7:0] src;
  logic [7:0] mask;
  logic       clear;

  logic [1:0]      d_valid;
  logic [1:0]      d_crit;
  logic [1:0][7:0] d_coreid;
  logic [1:0]      d_locked;
  logic [1:0][2:0] d_first;
  logic [1:0][7:0] d_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  critical_error_reporter #(
    .NUM_SRC(8), .SYNC_STAGES(2), .CNT_W(8), .HEARTBEAT_PERIOD(0)
  ) dut_a (
    .clock(clk), .reset(reset), .io_hartId(hart), .io_errSrc(src), .io_errMask(mask),
    .io_clear(clear), .io_event_valid(d_valid[0]), .io_event_critical(d_crit[0]),
    .io_event_coreid(d_coreid[0]), .io_locked(d_locked[0]), .io_firstSrc(d_first[0]),
    .io_errCount(d_cnt[0])
  );

  critical_error_reporter #(
    .NUM_SRC(8), .SYNC_STAGES(2), .CNT_W(8), .HEARTBEAT_PERIOD(16)
  ) dut_b (
    .clock(clk), .reset(reset), .io_hartId(hart), .io_errSrc(src), .io_errMask(mask),
    .io_clear(clear), .io_event_valid(d_valid[1]), .io_event_critical(d_crit[1]),
    .io_event_coreid(d_coreid[1]), .io_locked(d_locked[1]), .io_firstSrc(d_first[1]),
    .io_errCount(d_cnt[1])
  );

  // ------------------------------------------------------------------------------------------
  // Behavioural model. mode: 0 waiting, 1 reporting, 2 locked.
  // ------------------------------------------------------------------------------------------
  logic [7:0] hist [SYNC];
  int         m_mode   [2];
  logic       m_locked [2];
  int         m_first  [2];
  int         m_cnt    [2];
  int         m_hb     [2];
  logic       m_valid  [2];
  logic       m_crit   [2];
  logic [7:0] m_coreid [2];

  task automatic model_reset(input int k);
    m_mode[k] = 0; m_locked[k] = 1'b0; m_first[k] = 0; m_cnt[k] = 0; m_hb[k] = 0;
    m_valid[k] = 1'b0; m_crit[k] = 1'b0; m_coreid[k] = 8'h00;
  endtask

  task automatic model_step(input int k, input int period, input logic [7:0] hit);
    logic ev, cr, was_locked;
    bit   hb_runs;
    ev = 1'b0; cr = 1'b0;
    was_locked = m_locked[k];
    hb_runs = (period > 0) && (m_mode[k] != 1);
    if (m_mode[k] == 0 && hit != 0) begin
      m_mode[k] = 1; m_locked[k] = 1'b1; m_cnt[k] = 1; m_hb[k] = 0; ev = 1'b1; cr = 1'b1;
      for (int i = NSRC - 1; i >= 0; i--) if (hit[i]) m_first[k] = i;
    end else begin
      if (m_mode[k] == 1) begin
        m_mode[k] = 2;
        if (hit != 0) m_cnt[k] = (m_cnt[k] + 1 > CMAX) ? CMAX : m_cnt[k] + 1;
      end else if (m_mode[k] == 2) begin
        if (clear) begin
          m_mode[k] = 0; m_locked[k] = 1'b0; m_first[k] = 0; m_cnt[k] = 0;
        end else if (hit != 0) begin
          m_cnt[k] = (m_cnt[k] + 1 > CMAX) ? CMAX : m_cnt[k] + 1;
        end
      end
      if (hb_runs) begin
        if (m_hb[k] == period - 1) begin
          ev = 1'b1; cr = was_locked; m_hb[k] = 0;
        end else begin
          m_hb[k] = m_hb[k] + 1;
        end
      end
    end
    m_valid[k]  = ev;
    m_crit[k]   = cr;
    m_coreid[k] = ev ? hart : 8'h00;
  endtask

  // Model advances on the same edge as the DUTs; inputs change 1 time unit after each edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      model_reset(0);
      model_reset(1);
      for (int i = 0; i < SYNC; i++) hist[i] = 8'h00;
    end else begin
      model_step(0, 0, hist[SYNC-1] & mask);
      model_step(1, 16, hist[SYNC-1] & mask);
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = src;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_valid[%0d]", k),  32'(d_valid[k]),  32'(m_valid[k]));
        chk($sformatf("model_crit[%0d]", k),   32'(d_crit[k]),   32'(m_crit[k]));
        chk($sformatf("model_coreid[%0d]", k), 32'(d_coreid[k]), 32'(m_coreid[k]));
        chk($sformatf("model_locked[%0d]", k), 32'(d_locked[k]), 32'(m_locked[k]));
        chk($sformatf("model_first[%0d]", k),  32'(d_first[k]),  32'(m_first[k]));
        chk($sformatf("model_cnt[%0d]", k),    32'(d_cnt[k]),    32'(m_cnt[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lock();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
  endtask

  int last;
  int npulse;

  initial begin
    reset = 1'b1; hart = 8'd3; src = 8'h00; mask = 8'hFF; clear = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_valid", 32'(d_valid[0]), 32'd0);
    chk("rst_locked", 32'(d_locked[0]), 32'd0);
    chk("rst_cnt", 32'(d_cnt[0]), 32'd0);
    step();
    reset = 1'b0;
    repeat (5) step();

    // 1: one-cycle pulse on source 5, event three cycles later and only then.
    src = 8'h20;
    step();
    src = 8'h00;
    @(negedge clk);
    chk("t1_valid_c1", 32'(d_valid[0]), 32'd0);
    @(negedge clk);
    chk("t1_valid_c2", 32'(d_valid[0]), 32'd0);
    @(negedge clk);
    chk("t1_valid_c3", 32'(d_valid[0]), 32'd1);
    chk("t1_crit_c3", 32'(d_crit[0]), 32'd1);
    chk("t1_coreid_c3", 32'(d_coreid[0]), 32'd3);
    chk("t1_locked_c3", 32'(d_locked[0]), 32'd1);
    chk("t1_first_c3", 32'(d_first[0]), 32'd5);
    chk("t1_cnt_c3", 32'(d_cnt[0]), 32'd1);
    @(negedge clk);
    chk("t1_valid_c4", 32'(d_valid[0]), 32'd0);
    chk("t1_locked_c4", 32'(d_locked[0]), 32'd1);

    // 2: simultaneous sources, lowest enabled index wins.
    step();
    clear_lock();
    src = 8'h24;
    step();
    src = 8'h00;
    repeat (3) step();
    @(negedge clk);
    chk("t2_first_ff", 32'(d_first[0]), 32'd2);
    step();
    clear_lock();
    mask = 8'hFB;
    src  = 8'h24;
    step();
    src = 8'h00;
    repeat (3) step();
    @(negedge clk);
    chk("t2_first_fb", 32'(d_first[0]), 32'd5);
    mask = 8'hFF;

    // 3: level error while locked saturates the counter, no further event.
    step();
    src = 8'h01;
    repeat (300) step();
    @(negedge clk);
    chk("t3_cnt_sat", 32'(d_cnt[0]), 32'd255);
    chk("t3_no_event", 32'(d_valid[0]), 32'd0);
    chk("t3_first_frozen", 32'(d_first[0]), 32'd5);

    // 4: clear with a level source present re-triggers after one unlocked cycle.
    step();
    src = 8'h02;
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("t4_unlocked", 32'(d_locked[0]), 32'd0);
    chk("t4_cnt_cleared", 32'(d_cnt[0]), 32'd0);
    step();
    @(negedge clk);
    chk("t4_retrig_valid", 32'(d_valid[0]), 32'd1);
    chk("t4_retrig_first", 32'(d_first[0]), 32'd1);
    chk("t4_relocked", 32'(d_locked[0]), 32'd1);
    src = 8'h00;
    repeat (4) step();

    // 5: heartbeat every 16 cycles while idle with critical 0, then critical 1 once locked.
    clear_lock();
    repeat (2) step();
    last = -1;
    npulse = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (d_valid[1]) begin
        chk("t5_idle_hb_crit", 32'(d_crit[1]), 32'd0);
        if (last >= 0) chk("t5_hb_interval", 32'(i - last), 32'd16);
        last = i;
        npulse = npulse + 1;
      end
    end
    chk("t5_idle_hb_count", 32'(npulse), 32'd3);
    step();
    src = 8'h20;
    step();
    src = 8'h00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t5_report_valid", 32'(d_valid[1]), 32'd1);
    chk("t5_report_crit", 32'(d_crit[1]), 32'd1);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_valid[1]) begin
        chk("t5_locked_hb_crit", 32'(d_crit[1]), 32'd1);
        npulse = npulse + 1;
      end
    end
    chk("t5_locked_hb_count", 32'(npulse), 32'd2);

    // 6: reset during the report cycle, then re-arm.
    step();
    clear_lock();
    src = 8'h20;
    step();
    src = 8'h00;
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_report_valid", 32'(d_valid[0]), 32'd1);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_valid", 32'(d_valid[0]), 32'd0);
    chk("t6_rst_locked", 32'(d_locked[0]), 32'd0);
    chk("t6_rst_cnt", 32'(d_cnt[0]), 32'd0);
    step();
    src = 8'h08;
    step();
    src = 8'h00;
    step();
    step();
    @(negedge clk);
    chk("t6_rearm_valid", 32'(d_valid[0]), 32'd1);
    chk("t6_rearm_first", 32'(d_first[0]), 32'd3);
    chk("t6_rearm_locked", 32'(d_locked[0]), 32'd1);
    repeat (3) step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
